// File: rtl/test_status_pkg.sv
// Shared definitions for the test-status MMIO block: register word indices
// inside the 16-byte window, the FSM state type and STATUS bit positions.
package test_status_pkg;

  // Register word index (mem_addr[3:2]) within the window.
  localparam logic [1:0] REG_TOHOST  = 2'd0;  // 0x0, write-only
  localparam logic [1:0] REG_CONSOLE = 2'd1;  // 0x4, write-only
  localparam logic [1:0] REG_CYCLE   = 2'd2;  // 0x8, read-only
  localparam logic [1:0] REG_STATUS  = 2'd3;  // 0xC, read-only

  // Test lifecycle: running, waiting for console bytes to leave, stopped.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // STATUS register bit positions.
  localparam int STATUS_DONE_BIT     = 0;
  localparam int STATUS_PASS_BIT     = 1;
  localparam int STATUS_HALT_BIT     = 2;
  localparam int STATUS_TIMEOUT_BIT  = 3;
  localparam int STATUS_COUNT_LO_BIT = 4;
  localparam int STATUS_OVF_BIT      = 6;

  // Assemble the STATUS word from its fields.
  function automatic logic [31:0] pack_status(input logic overflow,
                                              input logic [1:0] count,
                                              input logic timeout,
                                              input logic halt_req,
                                              input logic pass,
                                              input logic done);
    logic [31:0] s;
    s = 32'd0;
    s[STATUS_OVF_BIT]                             = overflow;
    s[STATUS_COUNT_LO_BIT+1:STATUS_COUNT_LO_BIT]  = count;
    s[STATUS_TIMEOUT_BIT]                         = timeout;
    s[STATUS_HALT_BIT]                            = halt_req;
    s[STATUS_PASS_BIT]                            = pass;
    s[STATUS_DONE_BIT]                            = done;
    return s;
  endfunction

endpackage

// File: rtl/test_status_fifo.sv
// Two-entry console FIFO kept as a tiny shift structure: e0 is always the
// head, e1 the second entry. A push on a full FIFO succeeds only when a pop
// happens in the same cycle; otherwise it is refused (the caller flags it).
module test_status_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign head    = e0_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next entries and occupancy for every push/pop combination.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) e0_d = push_data;
        else                 e1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          e0_d = push_data;
        end else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/test_status_mmio.sv
// Test-status MMIO window: TOHOST exit register, console byte output,
// free-running cycle counter and STATUS word. Optional watchdog enabled by
// defining TEST_STATUS_WATCHDOG_EN; without it timeout is tied low.
// Bus handshake: a store/load is a single-cycle strobe (mem_we/mem_re) with
// no back-pressure; load data appears on mem_rdata one cycle later. Console
// uses valid/ready: a byte transfers on any cycle with con_valid&&con_ready,
// and con_valid/con_data stay stable until that transfer happens.
module test_status_mmio
  import test_status_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_hit,
  output logic [31:0] mem_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        halt_req,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] exit_code
);

  state_e      state_q, state_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] rdata_q, rdata_d;
  logic [30:0] exit_code_q, exit_code_d;
  logic        pass_q, pass_d;
  logic        overflow_q, overflow_d;

  logic [1:0]  word_sel;
  logic        wr_en, tohost_wr, con_push, con_pop, fifo_drop, wd_fire;
  logic        fifo_full, fifo_empty;
  logic [1:0]  fifo_count;

  assign mem_hit   = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign word_sel  = mem_addr[3:2];
  // Once halted the window accepts no stores at all.
  assign wr_en     = mem_we && mem_hit && (state_q != ST_HALTED);
  assign tohost_wr = wr_en && (state_q == ST_RUN) && (word_sel == REG_TOHOST) &&
                     (mem_wstrb == 4'hF) && mem_wdata[0];
  assign con_push  = wr_en && (word_sel == REG_CONSOLE) && mem_wstrb[0];
  assign con_pop   = con_valid && con_ready;
  assign fifo_drop = con_push && fifo_full && !con_pop;

  assign con_valid = !fifo_empty;
  assign halt_req  = (state_q != ST_RUN);
  assign done      = (state_q == ST_HALTED);
  assign pass      = pass_q;
  assign exit_code = exit_code_q;
  assign mem_rdata = rdata_q;

  test_status_fifo #(.WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (con_push),
    .push_data (mem_wdata[7:0]),
    .pop       (con_pop),
    .head      (con_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef TEST_STATUS_WATCHDOG_EN
  logic timeout_q, timeout_d;

  assign wd_fire = (state_q != ST_HALTED) && (cycle_q == TIMEOUT_CYCLES - 32'd1);
  assign timeout = timeout_q;

  // A TOHOST store in the same cycle beats the watchdog.
  always_comb begin
    timeout_d = timeout_q;
    if (wd_fire && !tohost_wr) timeout_d = 1'b1;
  end

  // Sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_d;
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state, result latching, cycle counter and load data.
  always_comb begin
    state_d     = state_q;
    exit_code_d = exit_code_q;
    pass_d      = pass_q;
    overflow_d  = overflow_q | fifo_drop;
    cycle_d     = cycle_q;
    rdata_d     = 32'd0;

    if (state_q != ST_HALTED && cycle_q != 32'hFFFF_FFFF) cycle_d = cycle_q + 32'd1;

    case (state_q)
      ST_RUN: begin
        if (tohost_wr) begin
          state_d     = ST_DRAIN;
          exit_code_d = mem_wdata[31:1];
          pass_d      = (mem_wdata[31:1] == 31'd0);
        end else if (wd_fire) begin
          state_d     = ST_HALTED;
          exit_code_d = '1;
          pass_d      = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (wd_fire) begin
          state_d     = ST_HALTED;
          exit_code_d = '1;
          pass_d      = 1'b0;
        end else if (fifo_empty) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase

    if (mem_re && mem_hit) begin
      case (word_sel)
        REG_CYCLE:  rdata_d = cycle_q;
        REG_STATUS: rdata_d = pack_status(overflow_q, fifo_count, timeout,
                                          halt_req, pass_q, done);
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  // State and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cycle_q     <= 32'd0;
      rdata_q     <= 32'd0;
      exit_code_q <= 31'd0;
      pass_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      rdata_q     <= rdata_d;
      exit_code_q <= exit_code_d;
      pass_q      <= pass_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: doc/test_status_mmio.md
TEST_STATUS_MMIO -- requirements
Module: test_status_mmio

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_1000: word-aligned base of a 16-byte register window.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 32'd5000: watchdog limit in clk cycles (5000 cycles = 50 us at a 10 ns clk).
REQ-003 The block SHALL have the following ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_we  in  1  CPU store strobe.
- mem_re  in  1  CPU load strobe.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data.
- mem_wstrb  in  4  store byte enables.
- mem_hit  out  1  address falls in the window.
- mem_rdata  out  32  load data.
- con_valid  out  1  console byte available.
- con_data  out  8  console byte.
- con_ready  in  1  sink accepts the byte.
- halt_req  out  1  asks the core to stop issuing.
- done  out  1  test finished.
- pass  out  1  test passed.
- timeout  out  1  watchdog fired.
- exit_code  out  31  test exit code.

Function
REQ-004 mem_hit SHALL be combinational: mem_addr[31:4]==BASE_ADDR[31:4].
REQ-005 Register offsets SHALL be: 0x0 TOHOST (W), 0x4 CONSOLE (W), 0x8 CYCLE (R), 0xC STATUS (R); reads of W-only offsets SHALL return 0.
REQ-006 mem_rdata SHALL be registered: valid one cycle after mem_re&&mem_hit, and 0 otherwise.
REQ-007 STATUS SHALL read {25'b0, overflow, fifo_count[1:0], timeout, halt_req, pass, done}.
REQ-008 The FSM SHALL have states RUN, DRAIN and HALTED.
REQ-009 In RUN, a write to TOHOST with mem_wstrb==4'hF and wdata[0]==1 SHALL latch exit_code=wdata[31:1] and pass=(wdata[31:1]==0), and SHALL enter DRAIN next cycle; writes with wdata[0]==0 SHALL be ignored.
REQ-010 halt_req SHALL be 1 in DRAIN and HALTED.
REQ-011 DRAIN SHALL go to HALTED on the cycle the console FIFO is empty; done SHALL be 1 only in HALTED.
REQ-012 CONSOLE writes with wstrb[0]==1 SHALL push wdata[7:0] into a 2-entry FIFO in RUN and DRAIN; a push when full SHALL be dropped and SHALL set sticky overflow.
REQ-013 con_valid SHALL equal FIFO non-empty, and con_data SHALL be the head entry; a pop SHALL occur on con_valid&&con_ready.
REQ-014 A simultaneous push and pop on a full FIFO SHALL succeed without overflow.
REQ-015 The cycle counter SHALL increment every cycle in RUN and DRAIN, SHALL freeze in HALTED, and SHALL saturate at 32'hFFFF_FFFF.
REQ-016 In HALTED, all writes SHALL be ignored, and the FIFO SHALL continue draining to the sink.

Reset
REQ-017 While rst=1 at a clk edge, the block SHALL set: state RUN, cycle 0, FIFO empty, overflow 0, done 0, pass 0, timeout 0, halt_req 0, exit_code 0, mem_rdata 0, con_valid 0.
REQ-018 Reset asserted in any state SHALL abort the state, clear the FIFO, and discard pending bytes.

Configuration
REQ-019 With macro TEST_STATUS_WATCHDOG_EN defined: in RUN or DRAIN, cycle==TIMEOUT_CYCLES-1 SHALL force HALTED next cycle with timeout=1, pass=0 and exit_code all ones.
REQ-020 If a TOHOST write and the timeout coincide, the TOHOST write SHALL win and timeout SHALL stay 0.
REQ-021 Without the macro, no watchdog logic SHALL exist, and timeout SHALL be tied to 0.

Structure
REQ-022 Package test_status_pkg SHALL hold the register offset constants, the state enum type and the STATUS bit indices.
REQ-023 The console FIFO SHALL be sub-module test_status_fifo (depth 2, width 8, with full/empty/count outputs).

Verification
REQ-024 The bench SHALL cover: store 32'h1 to 0x1000 with FIFO empty -> halt_req=1 next cycle, then done=1, pass=1, exit_code=0.
REQ-025 The bench SHALL cover: store 32'h0000_0007 to TOHOST -> pass=0, exit_code=3, done=1.
REQ-026 The bench SHALL cover: con_ready=0, 3 stores 'A','B','C' to 0x1004 -> 'A','B' held, overflow=1; then con_ready=1 -> 'A' then 'B' on consecutive cycles.
REQ-027 The bench SHALL cover: 2 bytes queued with con_ready=0, then TOHOST pass -> state stays DRAIN (done=0); after release, done=1 the cycle after the FIFO empties.
REQ-028 The bench SHALL cover, with TEST_STATUS_WATCHDOG_EN and TIMEOUT_CYCLES=100 and no TOHOST write: at cycle 100, timeout=1, done=1, pass=0; a subsequent TOHOST write is ignored.
REQ-029 The bench SHALL cover: load 0x1008 at cycle 10 -> mem_rdata=10 the next cycle; rst pulse in DRAIN -> all outputs return to their reset values.
